// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative Booth multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_POS1 = 3'd1,
    BD_NEG1 = 3'd2,
    BD_POS2 = 3'd3,
    BD_NEG2 = 3'd4
  } booth_digit_e;

  // Number of Booth digits needed for a WIDTH+1 bit extended multiplier.
  function automatic int unsigned iters(input int unsigned width, input int unsigned radix4);
    int unsigned n;
    n = (radix4 != 0) ? (width / 2 + 1) : (width + 1);
    return n;
  endfunction

  // Radix-2 recode from {b[i], b[i-1]}.
  function automatic booth_digit_e booth_r2(input logic [1:0] bits);
    booth_digit_e d;
    d = BD_ZERO;
    case (bits)
      2'b01:   d = BD_POS1;
      2'b10:   d = BD_NEG1;
      default: d = BD_ZERO;
    endcase
    return d;
  endfunction

  // Radix-4 recode from {b[i+1], b[i], b[i-1]}.
  function automatic booth_digit_e booth_r4(input logic [2:0] bits);
    booth_digit_e d;
    d = BD_ZERO;
    case (bits)
      3'b001, 3'b010: d = BD_POS1;
      3'b011:         d = BD_POS2;
      3'b100:         d = BD_NEG2;
      3'b101, 3'b110: d = BD_NEG1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: add the recoded multiple of the multiplicand, then shift right.
module booth_step
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RADIX4 = 0
) (
  input  logic [WIDTH+2:0]  acc_i,
  input  logic [WIDTH:0]    mcand_i,
  input  logic [RADIX4+1:0] recode_i,
  output logic [WIDTH+2:0]  acc_o,
  output logic [RADIX4:0]   shout_o
);

  localparam int unsigned AW = WIDTH + 3;
  localparam int unsigned SH = RADIX4 + 1;

  logic [AW-1:0] mc1;
  logic [AW-1:0] mc2;
  logic [AW-1:0] sum;
  booth_digit_e  digit;

  // Select the digit multiple and accumulate before the shift
  always_comb begin
    mc1   = {{2{mcand_i[WIDTH]}}, mcand_i};
    mc2   = {mcand_i[WIDTH], mcand_i, 1'b0};
    digit = BD_ZERO;
    sum   = acc_i;
    if (RADIX4 != 0) begin
      digit = booth_r4(3'(recode_i));
    end else begin
      digit = booth_r2(2'(recode_i));
    end
    case (digit)
      BD_POS1: sum = acc_i + mc1;
      BD_NEG1: sum = acc_i - mc1;
      BD_POS2: sum = acc_i + mc2;
      BD_NEG2: sum = acc_i - mc2;
      default: sum = acc_i;
    endcase
  end

  // Bits shifted out of the accumulator feed the top of the multiplier register
  assign acc_o   = AW'($signed(sum) >>> SH);
  assign shout_o = sum[SH-1:0];

endmodule

// File: rtl/param_seq_multiplier.sv
// Iterative Booth multiplier (radix-2 or radix-4) with valid/ready on both sides.
module param_seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RADIX4 = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int unsigned R4    = (RADIX4 != 0) ? 1 : 0;
  localparam int unsigned AW    = WIDTH + 3;
  localparam int unsigned MB    = WIDTH + 1 + R4;
  localparam int unsigned SH    = R4 + 1;
  localparam int unsigned ITERS = iters(WIDTH, R4);
  localparam int unsigned CW    = $clog2(ITERS + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      acc_q, acc_d, acc_step;
  logic [WIDTH:0]     mcand_q, mcand_d;
  logic [MB-1:0]      mplr_q, mplr_d;
  logic               prev_q, prev_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [SH-1:0]      shout;
  logic               load;

  // Single Booth step, wired for the selected radix
  if (R4 != 0) begin : g_radix4
    booth_step #(.WIDTH(WIDTH), .RADIX4(1)) u_step (
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
      .recode_i ({mplr_q[1:0], prev_q}),
      .acc_o    (acc_step),
      .shout_o  (shout)
    );
  end else begin : g_radix2
    booth_step #(.WIDTH(WIDTH), .RADIX4(0)) u_step (
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
      .recode_i ({mplr_q[0], prev_q}),
      .acc_o    (acc_step),
      .shout_o  (shout)
    );
  end

  // Next-state, datapath update and operand capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    prev_d   = prev_q;
    result_d = result_q;
    load     = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: load = in_valid;
        ST_CALC: begin
          // All digits consumed: {acc, mplr} now holds the full product
          if (cnt_q == CW'(ITERS)) begin
            state_d  = ST_DONE;
            result_d = (2*WIDTH)'({acc_q, mplr_q});
          end else begin
            acc_d  = acc_step;
            mplr_d = {shout, mplr_q[MB-1:SH]};
            prev_d = mplr_q[SH-1];
            cnt_d  = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (load) begin
      state_d = ST_CALC;
      cnt_d   = '0;
      acc_d   = '0;
      prev_d  = 1'b0;
      mcand_d = {a_signed & a[WIDTH-1], a};
      mplr_d  = MB'({{2{b_signed & b[WIDTH-1]}}, b});
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      prev_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      prev_q   <= prev_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = en & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

endmodule
